// File: rtl/m_useq_pkg.sv
// Shared definitions for the m_useq microcode sequencer.
package m_useq_pkg;

  typedef enum logic [1:0] {
    SN_SEQ      = 2'b00,
    SN_DISPATCH = 2'b01,
    SN_COND     = 2'b10,
    SN_CALL     = 2'b11
  } snext_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_e;

  // rinx value that turns a CALL/RET microword into a return
  localparam logic [7:0] RET_INX = 8'hFF;

endpackage

// File: rtl/m_useq_nxt.sv
// Next-index multiplexer for m_useq (purely combinational).
// Define MIDGETV_UCODE_CALL_EN to enable the one-level CALL/RET path.
module m_useq_nxt
  import m_useq_pkg::*;
#(
  parameter logic [7:0] IRQ_INX = 8'hF8
) (
  input  logic [1:0] i_sel,
  input  logic [7:0] i_rinx,
  input  logic [7:0] i_opc_inx,
  input  logic       i_brcond,
  input  logic       i_irq_pending,
`ifdef MIDGETV_UCODE_CALL_EN
  input  logic [7:0] i_retreg,
  output logic       o_call,
`endif
  output logic [7:0] o_nxt,
  output logic       o_dispatch,
  output logic       o_irq
);

  snext_e w_sel;

  assign w_sel = snext_e'(i_sel);

  always_comb begin
    o_nxt      = i_rinx;
    o_dispatch = 1'b0;
    o_irq      = 1'b0;
`ifdef MIDGETV_UCODE_CALL_EN
    o_call     = 1'b0;
`endif
    case (w_sel)
      SN_SEQ: o_nxt = i_rinx;
      SN_DISPATCH: begin
        if (i_irq_pending) begin
          o_nxt = IRQ_INX;
          o_irq = 1'b1;
        end else begin
          o_nxt      = i_opc_inx;
          o_dispatch = 1'b1;
        end
      end
      SN_COND: o_nxt = {i_rinx[7:1], i_brcond};
      SN_CALL: begin
`ifdef MIDGETV_UCODE_CALL_EN
        if (i_rinx == RET_INX) begin
          o_nxt = i_retreg;
        end else begin
          o_nxt  = i_rinx;
          o_call = 1'b1;
        end
`else
        o_nxt = i_rinx;
`endif
      end
      default: o_nxt = i_rinx;
    endcase
  end

endmodule

// File: rtl/m_useq.sv
// Microcode sequencer: BOOT/RUN/STALL control with registered index and acks.
// Define MIDGETV_UCODE_CALL_EN to add a one-level subroutine return register.
module m_useq
  import m_useq_pkg::*;
#(
  parameter logic [7:0]  BOOT_INX    = 8'h00,
  parameter logic [7:0]  IRQ_INX     = 8'hF8,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rinx,
  input  logic [1:0] s_next,
  input  logic [7:0] opc_inx,
  input  logic       brcond,
  input  logic       progress_ucode,
  input  logic       irq_pending,
  output logic [7:0] minx,
  output logic       dispatch_ack,
  output logic       irq_ack
);

  localparam logic [2:0] BOOT_LAST = 3'(BOOT_CYCLES - 1);

  state_e     r_state;
  logic [2:0] r_cnt;
  logic [7:0] w_nxt;
  logic       w_dispatch;
  logic       w_irq;
`ifdef MIDGETV_UCODE_CALL_EN
  logic [7:0] r_retreg;
  logic       w_call;
`endif

  m_useq_nxt #(
    .IRQ_INX (IRQ_INX)
  ) u_nxt (
    .i_sel         (s_next),
    .i_rinx        (rinx),
    .i_opc_inx     (opc_inx),
    .i_brcond      (brcond),
    .i_irq_pending (irq_pending),
`ifdef MIDGETV_UCODE_CALL_EN
    .i_retreg      (r_retreg),
    .o_call        (w_call),
`endif
    .o_nxt         (w_nxt),
    .o_dispatch    (w_dispatch),
    .o_irq         (w_irq)
  );

  // STALL shares the RUN path: resuming evaluates the held microword in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BOOT;
      r_cnt        <= '0;
      minx         <= BOOT_INX;
      dispatch_ack <= 1'b0;
      irq_ack      <= 1'b0;
`ifdef MIDGETV_UCODE_CALL_EN
      r_retreg     <= '0;
`endif
    end else begin
      case (r_state)
        ST_BOOT: begin
          minx         <= BOOT_INX;
          dispatch_ack <= 1'b0;
          irq_ack      <= 1'b0;
          if (r_cnt == BOOT_LAST) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_RUN, ST_STALL: begin
          if (progress_ucode) begin
            r_state      <= ST_RUN;
            minx         <= w_nxt;
            dispatch_ack <= w_dispatch;
            irq_ack      <= w_irq;
`ifdef MIDGETV_UCODE_CALL_EN
            if (w_call) r_retreg <= minx + 8'd1;
`endif
          end else begin
            r_state      <= ST_STALL;
            dispatch_ack <= 1'b0;
            irq_ack      <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_BOOT;
          r_cnt        <= '0;
          minx         <= BOOT_INX;
          dispatch_ack <= 1'b0;
          irq_ack      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_useq.sv
// Directed self-checking bench for m_useq.
// Honors MIDGETV_UCODE_CALL_EN for the CALL/RET expectations.
module tb_m_useq;

  logic       clk;
  logic       rst_n;
  logic [7:0] rinx;
  logic [1:0] s_next;
  logic [7:0] opc_inx;
  logic       brcond;
  logic       progress_ucode;
  logic       irq_pending;
  logic [7:0] minx;
  logic       dispatch_ack;
  logic       irq_ack;

  int unsigned n_chk;
  int unsigned n_err;

  m_useq #(
    .BOOT_INX    (8'h00),
    .IRQ_INX     (8'hF8),
    .BOOT_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rinx           (rinx),
    .s_next         (s_next),
    .opc_inx        (opc_inx),
    .brcond         (brcond),
    .progress_ucode (progress_ucode),
    .irq_pending    (irq_pending),
    .minx           (minx),
    .dispatch_ack   (dispatch_ack),
    .irq_ack        (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] m, input logic da, input logic ia);
    chk({tag, ".minx"}, minx, m);
    chk({tag, ".dack"}, {7'd0, dispatch_ack}, {7'd0, da});
    chk({tag, ".iack"}, {7'd0, irq_ack}, {7'd0, ia});
  endtask

  initial begin
    n_chk          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    s_next         = 2'b01;
    opc_inx        = 8'h5A;
    rinx           = 8'h00;
    brcond         = 1'b0;
    progress_ucode = 1'b1;
    irq_pending    = 1'b0;
    #1;
    chk_all("reset", 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // boot: two cycles at BOOT_INX with dispatch requested, then dispatch taken
    step; chk_all("boot1", 8'h00, 1'b0, 1'b0);
    step; chk_all("boot2", 8'h00, 1'b0, 1'b0);
    step; chk_all("boot_exit", 8'h5A, 1'b1, 1'b0);

    // conditional branch
    s_next = 2'b10; rinx = 8'h40; brcond = 1'b1;
    step; chk_all("cond1", 8'h41, 1'b0, 1'b0);
    brcond = 1'b0;
    step; chk_all("cond0", 8'h40, 1'b0, 1'b0);

    // dispatch without and with pending interrupt
    s_next = 2'b01; opc_inx = 8'h23; irq_pending = 1'b0;
    step; chk_all("disp", 8'h23, 1'b1, 1'b0);
    irq_pending = 1'b1;
    step; chk_all("irq", 8'hF8, 1'b0, 1'b1);
    // irq_pending ignored on SEQ and COND
    s_next = 2'b00; rinx = 8'h10;
    step; chk_all("seq_irq_ign", 8'h10, 1'b0, 1'b0);
    s_next = 2'b10; rinx = 8'h62; brcond = 1'b1;
    step; chk_all("cond_irq_ign", 8'h63, 1'b0, 1'b0);
    irq_pending = 1'b0;

    // stall: hold five cycles, then resume evaluating held microword
    s_next = 2'b00; rinx = 8'h07;
    step; chk_all("pre_stall", 8'h07, 1'b0, 1'b0);
    progress_ucode = 1'b0; rinx = 8'h10;
    for (int i = 0; i < 5; i++) begin
      step; chk_all("stall", 8'h07, 1'b0, 1'b0);
    end
    progress_ucode = 1'b1;
    step; chk_all("resume", 8'h10, 1'b0, 1'b0);

    // stall with a dispatch microword: no ack until resume
    s_next = 2'b01; opc_inx = 8'h3C; progress_ucode = 1'b0;
    step; chk_all("stall_disp", 8'h10, 1'b0, 1'b0);
    progress_ucode = 1'b1;
    step; chk_all("resume_disp", 8'h3C, 1'b1, 1'b0);

    // CALL/RET with wrap of return address
    s_next = 2'b00; rinx = 8'hFF;
    step; chk_all("to_ff", 8'hFF, 1'b0, 1'b0);
    s_next = 2'b11; rinx = 8'h80;
    step; chk_all("call", 8'h80, 1'b0, 1'b0);
    rinx = 8'hFF;
`ifdef MIDGETV_UCODE_CALL_EN
    step; chk_all("ret_wrap", 8'h00, 1'b0, 1'b0);
    // second CALL overwrites the return register
    rinx = 8'h20;
    step; chk_all("call_a", 8'h20, 1'b0, 1'b0);
    rinx = 8'h90;
    step; chk_all("call_b", 8'h90, 1'b0, 1'b0);
    rinx = 8'hFF;
    step; chk_all("ret_over", 8'h21, 1'b0, 1'b0);
`else
    step; chk_all("ret_as_seq", 8'hFF, 1'b0, 1'b0);
`endif

    // reset during STALL with dispatch pending
    s_next = 2'b00; rinx = 8'h55;
    step; chk_all("pre_rst", 8'h55, 1'b0, 1'b0);
    s_next = 2'b01; opc_inx = 8'h23; progress_ucode = 1'b0;
    step; chk_all("rst_stall", 8'h55, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1; chk_all("async_rst", 8'h00, 1'b0, 1'b0);
    progress_ucode = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step; chk_all("reboot1", 8'h00, 1'b0, 1'b0);
    step; chk_all("reboot2", 8'h00, 1'b0, 1'b0);
    step; chk_all("reboot_exit", 8'h23, 1'b1, 1'b0);
    s_next = 2'b00; rinx = 8'h01;
    step; chk_all("ack_pulse_end", 8'h01, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
